register_file: RTL and testbench

//   General-purpose register file for the 8-bit CPU datapath.
//   8 x 8-bit registers, two combinational read ports, one synchronous write port.

---
 rtl/register_file.sv | 57 +++++
 tb/tb_register_file.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module      : register_file
// Description : 2**ADDR_WIDTH x DATA_WIDTH register file with two combinational
//               read ports and one synchronous write port; the write index is
//               shared with read port 1. Optional macro REGFILE_ZERO_REG_EN
//               hardwires register 0 to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] read_reg1,
    input  logic [ADDR_WIDTH-1:0] read_reg2,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int c_NUM_REGS = 2 ** ADDR_WIDTH;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic c_ZERO_REG = 1'b1;
`else
    localparam logic c_ZERO_REG = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
    logic                  w_write_ok;
    logic                  w_rd1_zero;
    logic                  w_rd2_zero;

    assign w_write_ok = write_enable && !(c_ZERO_REG && (read_reg1 == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_write_ok) begin
            r_regs[read_reg1] <= write_data;
        end
    end

    // Index 0 is masked at the read mux so it reads 0 even before the first reset.
    assign w_rd1_zero = c_ZERO_REG && (read_reg1 == '0);
    assign w_rd2_zero = c_ZERO_REG && (read_reg2 == '0);

    assign read_data1 = w_rd1_zero ? '0 : r_regs[read_reg1];
    assign read_data2 = w_rd2_zero ? '0 : r_regs[read_reg2];

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file
// Description : Self-checking bench for register_file using a directed vector
//               table plus hand-written multi-cycle sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file;

    localparam int c_DW = 8;
    localparam int c_AW = 3;

`ifdef REGFILE_ZERO_REG_EN
    localparam logic [7:0] c_R0_EXP = 8'h00;
`else
    localparam logic [7:0] c_R0_EXP = 8'h3C;
`endif

    logic            clk;
    logic            rst;
    logic            write_enable;
    logic [c_AW-1:0] read_reg1;
    logic [c_AW-1:0] read_reg2;
    logic [c_DW-1:0] write_data;
    logic [c_DW-1:0] read_data1;
    logic [c_DW-1:0] read_data2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       we;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [7:0] wdata;
        logic [7:0] exp1;
        logic [7:0] exp2;
    } vec_t;

    vec_t vecs [12];

    register_file #(
        .DATA_WIDTH(c_DW),
        .ADDR_WIDTH(c_AW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .write_enable (write_enable),
        .read_reg1    (read_reg1),
        .read_reg2    (read_reg2),
        .write_data   (write_data),
        .read_data1   (read_data1),
        .read_data2   (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [7:0] wd);
        @(negedge clk);
        rst          = r;
        write_enable = we;
        read_reg1    = a1;
        read_reg2    = a2;
        write_data   = wd;
    endtask

    initial begin
        rst          = 1'b1;
        write_enable = 1'b0;
        read_reg1    = '0;
        read_reg2    = '0;
        write_data   = '0;

        //            rst   we    r1    r2    wdata  exp1     exp2
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00,    8'h00};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 3'd0, 8'hAA, 8'hAA,    8'h00};
        vecs[2]  = '{1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'hAA,    8'h00};
        vecs[3]  = '{1'b0, 1'b1, 3'd2, 3'd1, 8'hF0, 8'hF0,    8'hAA};
        vecs[4]  = '{1'b0, 1'b0, 3'd2, 3'd1, 8'h00, 8'hF0,    8'hAA};
        vecs[5]  = '{1'b0, 1'b0, 3'd3, 3'd2, 8'h55, 8'h00,    8'hF0};
        vecs[6]  = '{1'b0, 1'b1, 3'd7, 3'd7, 8'h81, 8'h81,    8'h81};
        vecs[7]  = '{1'b0, 1'b1, 3'd6, 3'd7, 8'hFF, 8'hFF,    8'h81};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 3'd0, 8'h3C, c_R0_EXP, c_R0_EXP};
        vecs[9]  = '{1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'hAA,    c_R0_EXP};
        vecs[10] = '{1'b1, 1'b1, 3'd4, 3'd1, 8'h77, 8'h00,    8'h00};
        vecs[11] = '{1'b0, 1'b0, 3'd4, 3'd6, 8'h00, 8'h00,    8'h00};

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].r1, vecs[i].r2, vecs[i].wdata);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rd1", i), read_data1, vecs[i].exp1);
            check($sformatf("vec%0d_rd2", i), read_data2, vecs[i].exp2);
        end

        // Sweep: everything cleared by the reset in vec 10, write_enable low.
        for (int a = 0; a < 8; a++) begin
            drive(1'b0, 1'b0, 3'(a), 3'(7 - a), 8'hEE);
            #1;
            check($sformatf("sweep_rd1_r%0d", a), read_data1, 8'h00);
            check($sformatf("sweep_rd2_r%0d", 7 - a), read_data2, 8'h00);
        end

        // Read during write: old value before the edge, new value after it.
        drive(1'b0, 1'b1, 3'd5, 3'd5, 8'h12);
        #1;
        check("rdw_pre_rd1", read_data1, 8'h00);
        check("rdw_pre_rd2", read_data2, 8'h00);
        @(posedge clk);
        #1;
        check("rdw_post_rd1", read_data1, 8'h12);
        check("rdw_post_rd2", read_data2, 8'h12);

        // Back-to-back writes to the same register with write_enable held.
        drive(1'b0, 1'b1, 3'd5, 3'd3, 8'h34);
        #1;
        check("b2b_pre_rd1", read_data1, 8'h12);
        @(posedge clk);
        #1;
        check("b2b_post_rd1", read_data1, 8'h34);
        check("b2b_other_rd2", read_data2, 8'h00);

        // Consecutive writes to different registers, then read both back.
        drive(1'b0, 1'b1, 3'd3, 3'd5, 8'hC3);
        @(posedge clk);
        drive(1'b0, 1'b0, 3'd3, 3'd5, 8'h00);
        #1;
        check("multi_rd1_r3", read_data1, 8'hC3);
        check("multi_rd2_r5", read_data2, 8'h34);

        // Write to index 0 after reset then read it via port 2.
        drive(1'b0, 1'b1, 3'd0, 3'd3, 8'h5A);
        @(posedge clk);
        drive(1'b0, 1'b0, 3'd3, 3'd0, 8'h00);
        #1;
`ifdef REGFILE_ZERO_REG_EN
        check("r0_rd2", read_data2, 8'h00);
`else
        check("r0_rd2", read_data2, 8'h5A);
`endif
        check("r0_rd1_r3", read_data1, 8'hC3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
